// File: rtl/softusb_txpkt_if.sv
// Command, payload and byte-stream signals between the packet assembler and its neighbours.
// The slave modport is the assembler's view; the master modport is the driver/consumer side.
interface softusb_txpkt_if;
  logic        start;
  logic [1:0]  kind;
  logic [3:0]  pid;
  logic [10:0] token;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        underrun;

  modport master (
    output start, kind, pid, token, data_in, data_valid, data_last, tx_ready,
    input  data_ready, tx_data, tx_valid, busy, done, underrun
  );

  modport slave (
    input  start, kind, pid, token, data_in, data_valid, data_last, tx_ready,
    output data_ready, tx_data, tx_valid, busy, done, underrun
  );
endinterface

// File: rtl/softusb_txpkt.sv
// USB packet assembler: turns a start command plus optional payload stream into
// SYNC/PID/body/CRC bytes for softusb_tx.
module softusb_txpkt #(
  parameter bit GEN_SYNC = 1'b1
) (
  input logic           usb_clk,
  input logic           usb_rst,
  softusb_txpkt_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SYNC, PID, TOK0, TOK1, DATA, CRCL, CRCH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  txData_q, txData_d;
  logic        txValid_q, txValid_d;
  logic [1:0]  kind_q, kind_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] token_q, token_d;
  logic [15:0] crc_q, crc_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;
  logic        dataReady;
  logic        xfer;
  logic        fetch;
  logic        finish;
  logic [15:0] crcOut;

  // Reflected-register form: bits enter LSB first, so the complemented register
  // already has the MSB of the conventional CRC5 in bit 0, ready to go out first.
  function automatic logic [4:0] crc5Token(input logic [10:0] t);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[0] ^ t[i];
      c  = c >> 1;
      if (fb) c = c ^ 5'h14;
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  assign xfer   = txValid_q && bus.tx_ready;
  assign crcOut = ~crc_q;

  always_comb begin
    state_d    = state_q;
    txData_d   = txData_q;
    txValid_d  = txValid_q;
    kind_d     = kind_q;
    pid_d      = pid_q;
    token_d    = token_q;
    crc_d      = crc_q;
    last_d     = last_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    dataReady  = 1'b0;
    fetch      = 1'b0;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          kind_d    = bus.kind;
          pid_d     = bus.pid;
          token_d   = bus.token;
          crc_d     = 16'hFFFF;
          last_d    = 1'b0;
          txValid_d = 1'b1;
          if (GEN_SYNC) begin
            state_d  = SYNC;
            txData_d = 8'h80;
          end else begin
            state_d  = PID;
            txData_d = {~bus.pid, bus.pid};
          end
        end
      end
      SYNC: begin
        if (xfer) begin
          state_d  = PID;
          txData_d = {~pid_q, pid_q};
        end
      end
      PID: begin
        if (xfer) begin
          case (kind_q)
            2'd0: finish = 1'b1;
            2'd1: begin
              state_d  = TOK0;
              txData_d = token_q[7:0];
            end
            2'd2: fetch = 1'b1;
            default: begin
              state_d  = CRCL;
              txData_d = crcOut[7:0];
            end
          endcase
        end
      end
      TOK0: begin
        if (xfer) begin
          state_d  = TOK1;
          txData_d = {crc5Token(token_q), token_q[10:8]};
        end
      end
      TOK1: begin
        if (xfer) finish = 1'b1;
      end
      DATA: begin
        if (xfer) begin
          if (last_q) begin
            state_d  = CRCL;
            txData_d = crcOut[7:0];
          end else begin
            fetch = 1'b1;
          end
        end
      end
      CRCL: begin
        if (xfer) begin
          state_d  = CRCH;
          txData_d = crcOut[15:8];
        end
      end
      CRCH: begin
        if (xfer) finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A payload byte is pulled on the same edge the previous byte leaves, or the packet is cut short.
    if (fetch) begin
      if (bus.data_valid) begin
        dataReady = 1'b1;
        state_d   = DATA;
        txData_d  = bus.data_in;
        crc_d     = crc16Byte(crc_q, bus.data_in);
        last_d    = bus.data_last;
      end else begin
        state_d    = IDLE;
        txValid_d  = 1'b0;
        done_d     = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (finish) begin
      state_d   = IDLE;
      txValid_d = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state_q    <= IDLE;
      txData_q   <= 8'h00;
      txValid_q  <= 1'b0;
      kind_q     <= 2'd0;
      pid_q      <= 4'h0;
      token_q    <= 11'h000;
      crc_q      <= 16'hFFFF;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txData_q   <= txData_d;
      txValid_q  <= txValid_d;
      kind_q     <= kind_d;
      pid_q      <= pid_d;
      token_q    <= token_d;
      crc_q      <= crc_d;
      last_q     <= last_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.tx_data    = txData_q;
  assign bus.tx_valid   = txValid_q;
  assign bus.data_ready = dataReady && !usb_rst;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_softusb_txpkt.sv
// Scoreboard bench for softusb_txpkt: expected bytes are queued by the stimulus,
// negedge monitors pop and compare every transferred byte.
module tb_softusb_txpkt;

  logic usb_clk = 1'b0;
  logic usb_rst;

  always #5 usb_clk = ~usb_clk;

  softusb_txpkt_if bus();
  softusb_txpkt_if bus0();

  softusb_txpkt #(.GEN_SYNC(1'b1)) u_dut (
    .usb_clk(usb_clk),
    .usb_rst(usb_rst),
    .bus    (bus)
  );

  softusb_txpkt #(.GEN_SYNC(1'b0)) u_dut0 (
    .usb_clk(usb_clk),
    .usb_rst(usb_rst),
    .bus    (bus0)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] expQ[$];
  logic [7:0] expQ0[$];
  logic [7:0] pl[$];
  int         pIdx = 0;
  int         stallAt = -1;
  logic       took = 1'b0;
  int         doneCnt = 0;
  int         doneCnt0 = 0;
  int         underrunCnt = 0;
  int         readyCnt = 0;
  logic       stalled = 1'b0;
  logic [7:0] stallData = 8'h00;

  logic [7:0] setupPayload [8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Conventional MSB-shifting CRC5, complemented then bit-reversed into transmit order.
  function automatic logic [4:0] modelCrc5(input logic [10:0] t);
    logic [4:0] c;
    logic [4:0] r;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ t[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    c = ~c;
    for (int i = 0; i < 5; i++) r[i] = c[4-i];
    return r;
  endfunction

  function automatic logic [15:0] modelCrc16();
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    foreach (pl[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ pl[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    c = ~c;
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

  // Monitor for the GEN_SYNC=1 instance.
  initial begin
    forever begin
      @(negedge usb_clk);
      took = bus.data_ready;
      if (usb_rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall tx_valid", {31'd0, bus.tx_valid}, 32'd1);
          checkOutput("stall tx_data", {24'd0, bus.tx_data}, {24'd0, stallData});
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected byte: got %0h expected none", bus.tx_data);
          end else begin
            checkOutput("tx byte", {24'd0, bus.tx_data}, {24'd0, expQ.pop_front()});
          end
        end
        stalled   = bus.tx_valid && !bus.tx_ready;
        stallData = bus.tx_data;
        if (bus.done) begin
          doneCnt++;
          checkOutput("busy at done", {31'd0, bus.busy}, 32'd0);
          checkOutput("tx_valid at done", {31'd0, bus.tx_valid}, 32'd0);
        end
        if (bus.underrun) begin
          underrunCnt++;
          checkOutput("underrun with done", {31'd0, bus.done}, 32'd1);
        end
        if (bus.data_ready) readyCnt++;
      end
    end
  end

  // Monitor for the GEN_SYNC=0 instance.
  initial begin
    forever begin
      @(negedge usb_clk);
      if (!usb_rst) begin
        if (bus0.tx_valid && bus0.tx_ready) begin
          if (expQ0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL nosync unexpected byte: got %0h expected none", bus0.tx_data);
          end else begin
            checkOutput("nosync tx byte", {24'd0, bus0.tx_data}, {24'd0, expQ0.pop_front()});
          end
        end
        if (bus0.done) doneCnt0++;
      end
    end
  end

  // Payload source: presents pl[pIdx] and advances when the DUT took it.
  initial begin
    forever begin
      @(posedge usb_clk);
      #1;
      if (took) pIdx++;
      took = 1'b0;
      if (pIdx < pl.size() && pIdx != stallAt) begin
        bus.data_valid = 1'b1;
        bus.data_in    = pl[pIdx];
        bus.data_last  = (pIdx == pl.size() - 1);
      end else begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        bus.data_last  = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] kind, input logic [3:0] pid, input logic [10:0] token);
    @(posedge usb_clk);
    #1;
    bus.start = 1'b1;
    bus.kind  = kind;
    bus.pid   = pid;
    bus.token = token;
    @(posedge usb_clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus0(input logic [1:0] kind, input logic [3:0] pid);
    @(posedge usb_clk);
    #1;
    bus0.start = 1'b1;
    bus0.kind  = kind;
    bus0.pid   = pid;
    @(posedge usb_clk);
    #1;
    bus0.start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int startCnt;
    int n;
    startCnt = doneCnt;
    n = 0;
    while (doneCnt == startCnt && n < budget) begin
      @(posedge usb_clk);
      n++;
    end
    if (doneCnt == startCnt) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done expected done within %0d cycles", name, budget);
    end
    repeat (2) @(posedge usb_clk);
    checkOutput({name, " leftover"}, expQ.size(), 32'd0);
  endtask

  task automatic waitDone0(input string name, input int budget);
    int startCnt;
    int n;
    startCnt = doneCnt0;
    n = 0;
    while (doneCnt0 == startCnt && n < budget) begin
      @(posedge usb_clk);
      n++;
    end
    if (doneCnt0 == startCnt) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done expected done within %0d cycles", name, budget);
    end
    repeat (2) @(posedge usb_clk);
    checkOutput({name, " leftover"}, expQ0.size(), 32'd0);
  endtask

  task automatic loadSetupPayload();
    pl.delete();
    pIdx = 0;
    stallAt = -1;
    foreach (setupPayload[i]) pl.push_back(setupPayload[i]);
  endtask

  task automatic pushSetupExpect();
    expQ.push_back(8'h80);
    expQ.push_back(8'hC3);
    foreach (setupPayload[i]) expQ.push_back(setupPayload[i]);
    expQ.push_back(8'hDD);
    expQ.push_back(8'h94);
  endtask

  task automatic pushSetupToken();
    expQ.push_back(8'h80);
    expQ.push_back(8'h2D);
    expQ.push_back(8'h00);
    expQ.push_back(8'h10);
  endtask

  initial begin
    int rc;
    int uc;
    logic [15:0] crc;
    logic [4:0]  c5;
    logic [10:0] tok;

    usb_rst = 1'b1;
    bus.start = 1'b0;  bus.kind = 2'd0;  bus.pid = 4'h0;  bus.token = 11'h000;
    bus.data_in = 8'h00;  bus.data_valid = 1'b0;  bus.data_last = 1'b0;  bus.tx_ready = 1'b1;
    bus0.start = 1'b0; bus0.kind = 2'd0; bus0.pid = 4'h0; bus0.token = 11'h000;
    bus0.data_in = 8'h00; bus0.data_valid = 1'b0; bus0.data_last = 1'b0; bus0.tx_ready = 1'b1;

    repeat (3) @(posedge usb_clk);
    @(negedge usb_clk);
    checkOutput("reset tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    checkOutput("reset tx_data", {24'd0, bus.tx_data}, 32'd0);
    checkOutput("reset data_ready", {31'd0, bus.data_ready}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset underrun", {31'd0, bus.underrun}, 32'd0);
    checkOutput("reset nosync busy", {31'd0, bus0.busy}, 32'd0);
    @(posedge usb_clk);
    #1;
    usb_rst = 1'b0;

    $display("[TB] SETUP token");
    pushSetupToken();
    applyStimulus(2'd1, 4'hD, 11'h000);
    waitDone("setup token", 50);

    $display("[TB] IN token endp A addr 15");
    tok = {4'hA, 7'h15};
    c5  = modelCrc5(tok);
    expQ.push_back(8'h80);
    expQ.push_back(8'h69);
    expQ.push_back(8'h15);
    expQ.push_back({c5, 3'b101});
    applyStimulus(2'd1, 4'h9, tok);
    waitDone("in token", 50);

    $display("[TB] DATA0 setup payload");
    loadSetupPayload();
    pushSetupExpect();
    rc = readyCnt;
    applyStimulus(2'd2, 4'h3, 11'h000);
    waitDone("data0 setup", 100);
    checkOutput("data_ready count", readyCnt - rc, 32'd8);

    $display("[TB] DATA1 two bytes");
    pl.delete(); pIdx = 0; stallAt = -1;
    pl.push_back(8'hA5); pl.push_back(8'h3C);
    crc = modelCrc16();
    expQ.push_back(8'h80); expQ.push_back(8'h4B);
    expQ.push_back(8'hA5); expQ.push_back(8'h3C);
    expQ.push_back(crc[7:0]); expQ.push_back(crc[15:8]);
    applyStimulus(2'd2, 4'hB, 11'h000);
    waitDone("data1 short", 100);

    $display("[TB] zero-length and handshake");
    pl.delete(); pIdx = 0;
    expQ.push_back(8'h80); expQ.push_back(8'h4B); expQ.push_back(8'h00); expQ.push_back(8'h00);
    applyStimulus(2'd3, 4'hB, 11'h000);
    waitDone("zero length", 50);
    expQ.push_back(8'h80); expQ.push_back(8'hD2);
    applyStimulus(2'd0, 4'h2, 11'h000);
    waitDone("handshake", 50);
    checkOutput("handshake tx_valid after", {31'd0, bus.tx_valid}, 32'd0);

    $display("[TB] no SYNC instance");
    expQ0.push_back(8'h4B); expQ0.push_back(8'h00); expQ0.push_back(8'h00);
    applyStimulus0(2'd3, 4'hB);
    waitDone0("nosync zero length", 50);
    expQ0.push_back(8'hD2);
    applyStimulus0(2'd0, 4'h2);
    waitDone0("nosync handshake", 50);

    $display("[TB] underrun after two bytes");
    pl.delete(); pIdx = 0; stallAt = 2;
    pl.push_back(8'hA1); pl.push_back(8'hB2); pl.push_back(8'hC3); pl.push_back(8'hD4);
    expQ.push_back(8'h80); expQ.push_back(8'hC3); expQ.push_back(8'hA1); expQ.push_back(8'hB2);
    rc = readyCnt; uc = underrunCnt;
    applyStimulus(2'd2, 4'h3, 11'h000);
    waitDone("underrun mid", 100);
    checkOutput("underrun mid count", underrunCnt - uc, 32'd1);
    checkOutput("underrun mid ready", readyCnt - rc, 32'd2);

    $display("[TB] underrun on prefetch");
    pl.delete(); pIdx = 0; stallAt = 0;
    pl.push_back(8'h11);
    expQ.push_back(8'h80); expQ.push_back(8'hC3);
    rc = readyCnt; uc = underrunCnt;
    applyStimulus(2'd2, 4'h3, 11'h000);
    waitDone("underrun prefetch", 100);
    checkOutput("underrun prefetch count", underrunCnt - uc, 32'd1);
    checkOutput("underrun prefetch ready", readyCnt - rc, 32'd0);
    stallAt = -1;

    $display("[TB] start while busy then reset mid DATA");
    loadSetupPayload();
    pushSetupExpect();
    applyStimulus(2'd2, 4'h3, 11'h000);
    repeat (2) @(posedge usb_clk);
    applyStimulus(2'd0, 4'h2, 11'h000);
    repeat (2) @(posedge usb_clk);
    #1;
    rc = doneCnt;
    bus.tx_ready = 1'b0;
    usb_rst = 1'b1;
    expQ.delete();
    @(negedge usb_clk);
    @(negedge usb_clk);
    checkOutput("rst tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    checkOutput("rst busy", {31'd0, bus.busy}, 32'd0);
    @(posedge usb_clk);
    #1;
    usb_rst = 1'b0;
    bus.tx_ready = 1'b1;
    pl.delete(); pIdx = 0;
    checkOutput("rst no done", doneCnt - rc, 32'd0);
    pushSetupToken();
    applyStimulus(2'd1, 4'hD, 11'h000);
    waitDone("setup after reset", 50);

    $display("[TB] tx_ready stall");
    loadSetupPayload();
    pushSetupExpect();
    rc = readyCnt;
    applyStimulus(2'd2, 4'h3, 11'h000);
    repeat (4) @(posedge usb_clk);
    #1;
    bus.tx_ready = 1'b0;
    repeat (100) @(posedge usb_clk);
    #1;
    bus.tx_ready = 1'b1;
    waitDone("stall", 300);
    checkOutput("stall data_ready count", readyCnt - rc, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
